// File: rtl/otp_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : otp_entry_ctrl
// Brief    : Two-button one-time-pad entry: message and key letters are typed,
//            then streamed out one combined letter per cycle.
//            Optional macro OTP_DECRYPT_EN adds mode_dec (subtract the key).
// Revision : 1.0 - initial release
// ============================================================================
module otp_entry_ctrl #(
  parameter int MSG_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_btn,
  input  logic       commit_btn,
`ifdef OTP_DECRYPT_EN
  input  logic       mode_dec,
`endif
  output logic [4:0] letter_sel,
  output logic [1:0] phase,
  output logic [3:0] idx,
  output logic       result_valid,
  output logic [4:0] result_letter,
  output logic [3:0] result_idx
);

  typedef enum logic [1:0] {
    S_MSG  = 2'd0,
    S_KEY  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] c_LAST_IDX    = 4'(MSG_LEN - 1);
  localparam logic [4:0] c_LAST_LETTER = 5'd25;

  state_t     r_state, w_state_nx;
  logic [4:0] r_letter, w_letter_nx;
  logic [3:0] r_idx, w_idx_nx;
  logic       r_inc_q, r_com_q;
  logic       w_inc_edge, w_com_edge;
  logic       w_wr_msg, w_wr_key;
  logic [4:0] r_msg_buf [16];
  logic [4:0] r_key_buf [16];
  logic [5:0] w_sum;
  logic [4:0] w_enc;
  logic [4:0] w_res;
  logic       w_show;

  // History simply tracks the levels every cycle, so reset also preloads it
  // and a button held through reset produces no edge afterwards.
  always_ff @(posedge clk) begin
    r_inc_q <= inc_btn;
    r_com_q <= commit_btn;
  end

  assign w_inc_edge = inc_btn & ~r_inc_q;
  assign w_com_edge = commit_btn & ~r_com_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_MSG;
      r_letter <= 5'd0;
      r_idx    <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_letter <= w_letter_nx;
      r_idx    <= w_idx_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_letter_nx = r_letter;
    w_idx_nx    = r_idx;
    w_wr_msg    = 1'b0;
    w_wr_key    = 1'b0;
    case (r_state)
      S_MSG, S_KEY: begin
        // Commit takes priority; a simultaneous inc edge is dropped.
        if (w_com_edge) begin
          w_wr_msg    = (r_state == S_MSG);
          w_wr_key    = (r_state == S_KEY);
          w_letter_nx = 5'd0;
          if (r_idx == c_LAST_IDX) begin
            w_idx_nx   = 4'd0;
            w_state_nx = (r_state == S_MSG) ? S_KEY : S_CALC;
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end else if (w_inc_edge) begin
          w_letter_nx = (r_letter == c_LAST_LETTER) ? 5'd0 : r_letter + 5'd1;
        end
      end
      S_CALC: begin
        // idx stays on the last position so DONE keeps showing the final result.
        if (r_idx == c_LAST_IDX) begin
          w_state_nx = S_DONE;
        end else begin
          w_idx_nx = r_idx + 4'd1;
        end
      end
      default: begin
        if (w_com_edge) begin
          w_state_nx  = S_MSG;
          w_idx_nx    = 4'd0;
          w_letter_nx = 5'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_msg) r_msg_buf[r_idx] <= r_letter;
    if (w_wr_key) r_key_buf[r_idx] <= r_letter;
  end

  assign w_sum = {1'b0, r_msg_buf[r_idx]} + {1'b0, r_key_buf[r_idx]};
  assign w_enc = (w_sum >= 6'd26) ? 5'(w_sum - 6'd26) : w_sum[4:0];

`ifdef OTP_DECRYPT_EN
  logic       r_mode;
  logic [5:0] w_diff;
  logic [4:0] w_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (r_state == S_KEY && w_com_edge && r_idx == c_LAST_IDX) begin
      r_mode <= mode_dec;
    end
  end

  // Bit 5 of the 6-bit difference is the borrow; add 26 back when set.
  assign w_diff = {1'b0, r_msg_buf[r_idx]} - {1'b0, r_key_buf[r_idx]};
  assign w_dec  = w_diff[5] ? 5'(w_diff + 6'd26) : w_diff[4:0];
  assign w_res  = r_mode ? w_dec : w_enc;
`else
  assign w_res  = w_enc;
`endif

  assign w_show        = (r_state == S_CALC) || (r_state == S_DONE);
  assign letter_sel    = r_letter;
  assign phase         = r_state;
  assign idx           = r_idx;
  assign result_valid  = (r_state == S_CALC);
  assign result_letter = w_show ? w_res : 5'd0;
  assign result_idx    = w_show ? r_idx : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_otp_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_otp_entry_ctrl
// Brief    : Directed self-checking bench for otp_entry_ctrl (MSG_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_otp_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc_btn = 1'b0;
  logic       commit_btn = 1'b0;
`ifdef OTP_DECRYPT_EN
  logic       mode_dec = 1'b0;
`endif
  logic [4:0] letter_sel;
  logic [1:0] phase;
  logic [3:0] idx;
  logic       result_valid;
  logic [4:0] result_letter;
  logic [3:0] result_idx;

  int pass_cnt  = 0;
  int total_cnt = 0;

  otp_entry_ctrl #(.MSG_LEN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inc_btn      (inc_btn),
    .commit_btn   (commit_btn),
`ifdef OTP_DECRYPT_EN
    .mode_dec     (mode_dec),
`endif
    .letter_sel   (letter_sel),
    .phase        (phase),
    .idx          (idx),
    .result_valid (result_valid),
    .result_letter(result_letter),
    .result_idx   (result_idx)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inc_btn    = 1'b0;
    commit_btn = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic press_inc();
    inc_btn = 1'b1;
    tick();
    inc_btn = 1'b0;
    tick();
  endtask

  task automatic press_commit();
    commit_btn = 1'b1;
    tick();
    commit_btn = 1'b0;
    tick();
  endtask

  // When last is set the trailing release cycle is skipped so the caller
  // observes the first CALC cycle directly.
  task automatic enter_letter(input int v, input bit last);
    repeat (v) press_inc();
    commit_btn = 1'b1;
    tick();
    commit_btn = 1'b0;
    if (!last) tick();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (phase !== 2'd0 || letter_sel !== 5'd0 || idx !== 4'd0 ||
        result_valid !== 1'b0 || result_letter !== 5'd0 || result_idx !== 4'd0)
      $display("FAIL reset: phase=%0d letter=%0d idx=%0d valid=%0b rl=%0d ri=%0d expected all 0",
               phase, letter_sel, idx, result_valid, result_letter, result_idx);
    else pass_cnt++;
  endtask

  task automatic test_inc_wrap();
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      press_inc();
      total_cnt++;
      if (letter_sel !== 5'(i % 26))
        $display("FAIL inc_wrap step %0d: letter_sel=%0d expected %0d", i, letter_sel, i % 26);
      else pass_cnt++;
    end
    total_cnt++;
    if (phase !== 2'd0 || idx !== 4'd0)
      $display("FAIL inc_wrap phase/idx: phase=%0d idx=%0d expected 0/0", phase, idx);
    else pass_cnt++;
  endtask

  task automatic run_calc(input logic [19:0] m, input logic [19:0] k,
                          input logic [19:0] e, input string name);
    do_reset();
    for (int i = 0; i < 4; i++) enter_letter(int'(m[5*i +: 5]), 1'b0);
    total_cnt++;
    if (phase !== 2'd1 || idx !== 4'd0 || letter_sel !== 5'd0)
      $display("FAIL %s msg_done: phase=%0d idx=%0d letter=%0d expected 1/0/0",
               name, phase, idx, letter_sel);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) enter_letter(int'(k[5*i +: 5]), i == 3);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (phase !== 2'd2 || result_valid !== 1'b1 || result_idx !== 4'(i) ||
          result_letter !== e[5*i +: 5])
        $display("FAIL %s calc%0d: phase=%0d valid=%0b ri=%0d rl=%0d expected 2/1/%0d/%0d",
                 name, i, phase, result_valid, result_idx, result_letter, i, e[5*i +: 5]);
      else pass_cnt++;
      // An inc edge during CALC must not disturb the stream.
      inc_btn = (i == 1);
      tick();
    end
    inc_btn = 1'b0;
    for (int j = 0; j < 2; j++) begin
      total_cnt++;
      if (phase !== 2'd3 || result_valid !== 1'b0 || result_idx !== 4'd3 ||
          result_letter !== e[19:15])
        $display("FAIL %s done%0d: phase=%0d valid=%0b ri=%0d rl=%0d expected 3/0/3/%0d",
                 name, j, phase, result_valid, result_idx, result_letter, e[19:15]);
      else pass_cnt++;
      tick();
    end
    press_inc();
    total_cnt++;
    if (phase !== 2'd3 || letter_sel !== 5'd0)
      $display("FAIL %s done_inc: phase=%0d letter=%0d expected 3/0", name, phase, letter_sel);
    else pass_cnt++;
    press_commit();
    total_cnt++;
    if (phase !== 2'd0 || idx !== 4'd0 || letter_sel !== 5'd0 || result_valid !== 1'b0)
      $display("FAIL %s restart: phase=%0d idx=%0d letter=%0d valid=%0b expected 0/0/0/0",
               name, phase, idx, letter_sel, result_valid);
    else pass_cnt++;
  endtask

  task automatic test_encrypt();
`ifdef OTP_DECRYPT_EN
    mode_dec = 1'b0;
`endif
    run_calc({5'd11, 5'd11, 5'd4, 5'd7}, {5'd14, 5'd0, 5'd25, 5'd3},
             {5'd25, 5'd11, 5'd3, 5'd10}, "encrypt");
  endtask

`ifdef OTP_DECRYPT_EN
  task automatic test_decrypt();
    mode_dec = 1'b1;
    run_calc({5'd25, 5'd11, 5'd3, 5'd10}, {5'd14, 5'd0, 5'd25, 5'd3},
             {5'd11, 5'd11, 5'd4, 5'd7}, "decrypt");
    mode_dec = 1'b0;
  endtask
`endif

  task automatic test_simultaneous();
    do_reset();
    repeat (5) press_inc();
    inc_btn    = 1'b1;
    commit_btn = 1'b1;
    tick();
    inc_btn    = 1'b0;
    commit_btn = 1'b0;
    total_cnt++;
    if (letter_sel !== 5'd0 || idx !== 4'd1 || phase !== 2'd0)
      $display("FAIL simultaneous: letter=%0d idx=%0d phase=%0d expected 0/1/0",
               letter_sel, idx, phase);
    else pass_cnt++;
    tick();
    for (int i = 0; i < 3; i++) enter_letter(0, 1'b0);
    for (int i = 0; i < 4; i++) enter_letter(0, i == 3);
    total_cnt++;
    if (result_valid !== 1'b1 || result_idx !== 4'd0 || result_letter !== 5'd5)
      $display("FAIL simultaneous_buf: valid=%0b ri=%0d rl=%0d expected 1/0/5",
               result_valid, result_idx, result_letter);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    do_reset();
    inc_btn = 1'b1;
    repeat (50) tick();
    total_cnt++;
    if (letter_sel !== 5'd1)
      $display("FAIL hold_inc: letter_sel=%0d expected 1", letter_sel);
    else pass_cnt++;
    inc_btn = 1'b0;
    tick();
    inc_btn = 1'b1;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if (letter_sel !== 5'd0)
      $display("FAIL hold_reset: letter_sel=%0d expected 0", letter_sel);
    else pass_cnt++;
    inc_btn = 1'b0;
    tick();
  endtask

  task automatic test_rst_calc();
    do_reset();
    for (int i = 0; i < 4; i++) enter_letter(1, 1'b0);
    for (int i = 0; i < 4; i++) enter_letter(2, i == 3);
    tick();
    total_cnt++;
    if (result_valid !== 1'b1 || result_idx !== 4'd1 || result_letter !== 5'd3)
      $display("FAIL rst_calc_pre: valid=%0b ri=%0d rl=%0d expected 1/1/3",
               result_valid, result_idx, result_letter);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b0 || phase !== 2'd0 || idx !== 4'd0 || letter_sel !== 5'd0)
      $display("FAIL rst_calc: valid=%0b phase=%0d idx=%0d letter=%0d expected 0/0/0/0",
               result_valid, phase, idx, letter_sel);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_encrypt();
`ifdef OTP_DECRYPT_EN
    test_decrypt();
`endif
    test_simultaneous();
    test_hold();
    test_rst_calc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
